scm_req_frontend: RTL

SCM_REQ_FRONTEND -- requirements
Module: scm_req_frontend

---
 rtl/scm_req_frontend_if.sv | 37 +++
 rtl/scm_req_frontend.sv | 97 +++++++++
 2 files changed

// File: rtl/scm_req_frontend_if.sv
// rtl/scm_req_frontend_if.sv - request/response and register-file port bundle for scm_req_frontend
interface scm_req_frontend_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH / 8
);
    logic                    ReqValid;
    logic                    ReqReady;
    logic                    ReqWrite;
    logic [ADDR_WIDTH-1:0]   ReqAddr;
    logic [NUM_BYTE*8-1:0]   ReqWData;
    logic [NUM_BYTE-1:0]     ReqBE;
    logic                    RespValid;
    logic                    RespReady;
    logic [DATA_WIDTH-1:0]   RespData;
    logic                    RfReadEnable;
    logic [ADDR_WIDTH-1:0]   RfReadAddr;
    logic [DATA_WIDTH-1:0]   RfReadData;
    logic                    RfWriteEnable;
    logic [ADDR_WIDTH-1:0]   RfWriteAddr;
    logic [NUM_BYTE*8-1:0]   RfWriteData;
    logic [NUM_BYTE-1:0]     RfWriteBE;
    logic                    Idle;

    // Requester and register file together form the environment side.
    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE, RespReady, RfReadData,
        input  ReqReady, RespValid, RespData, RfReadEnable, RfReadAddr,
               RfWriteEnable, RfWriteAddr, RfWriteData, RfWriteBE, Idle
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE, RespReady, RfReadData,
        output ReqReady, RespValid, RespData, RfReadEnable, RfReadAddr,
               RfWriteEnable, RfWriteAddr, RfWriteData, RfWriteBE, Idle
    );
endinterface

// File: rtl/scm_req_frontend.sv
// rtl/scm_req_frontend.sv - valid/ready frontend for port 0 of the latch register file with response FIFO
module scm_req_frontend #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH / 8,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    scm_req_frontend_if.slave bus
);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);

    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_BYTE*8-1:0]  req_wdata;
    logic [NUM_BYTE-1:0]    req_be;
    logic [DATA_WIDTH-1:0]  rd_data;

    logic [CW-1:0]          count;
    logic                   inflight;
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [DATA_WIDTH-1:0]  fifo_mem [RESP_DEPTH];

    logic                   req_ready;
    logic                   resp_valid;
    logic                   acc;
    logic                   pop;
    logic                   push;
    logic                   rd_acc;
    logic [CW:0]            credit;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_addr  = bus.ReqAddr;
    assign req_wdata = bus.ReqWData;
    assign req_be    = bus.ReqBE;
    assign rd_data   = bus.RfReadData;

    assign resp_valid = (count != '0);
    assign pop        = resp_valid & bus.RespReady;
    // The read issued last cycle lands in the FIFO this cycle.
    assign push       = inflight;

    // Credit counts both buffered entries and the read still on its way;
    // a pop this cycle frees a slot immediately (RespReady -> ReqReady path).
    assign credit    = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign req_ready = !rst && (credit < (CW+1)'(RESP_DEPTH));

    assign acc    = bus.ReqValid & req_ready;
    assign rd_acc = acc & ~bus.ReqWrite;

    assign bus.ReqReady      = req_ready;
    assign bus.RespValid     = resp_valid;
    assign bus.RespData      = fifo_mem[rptr];
    assign bus.RfReadEnable  = rd_acc;
    assign bus.RfReadAddr    = req_addr;
    assign bus.RfWriteEnable = acc & bus.ReqWrite;
    assign bus.RfWriteAddr   = req_addr;
    assign bus.RfWriteData   = req_wdata;
    assign bus.RfWriteBE     = req_be;
    assign bus.Idle          = (count == '0) & ~inflight;

    // Occupancy, in-flight flag and FIFO pointers; reset drops every pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            inflight <= rd_acc;
            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Response storage; a push into the slot being popped is safe because the
    // head is consumed combinationally before the edge.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= rd_data;
        end
    end
endmodule
